// File: rtl/wb_pkg.sv
// Shared types and constants for the register write-back queue.
package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // Register $0 is hard-wired; writes to it are swallowed.
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Producer handshakes, register-file write port and ID-stage lookup port
// of the write-back queue.
interface reg_writeback_queue_if #(
  parameter int ADDR_W = wb_pkg::WB_ADDR_W,
  parameter int DATA_W = wb_pkg::WB_DATA_W
);

  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;

  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;

  logic              hold_i;

  logic              RegWrite_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;

  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic              RShit_o;
  logic              RThit_o;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;

  modport master (
    output mem_valid_i, mem_addr_i, mem_data_i,
    output alu_valid_i, alu_addr_i, alu_data_i,
    output hold_i, RSaddr_i, RTaddr_i,
    input  mem_ready_o, alu_ready_o,
    input  RegWrite_o, RDaddr_o, RDdata_o,
    input  RShit_o, RThit_o, RSdata_o, RTdata_o
  );

  modport slave (
    input  mem_valid_i, mem_addr_i, mem_data_i,
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  hold_i, RSaddr_i, RTaddr_i,
    output mem_ready_o, alu_ready_o,
    output RegWrite_o, RDaddr_o, RDdata_o,
    output RShit_o, RThit_o, RSdata_o, RTdata_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous DEPTH-entry FIFO. Entries are exposed oldest-first with a
// per-entry valid so the parent can search every pending write.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  entry_t                     push_entry_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output entry_t                     entries_o [DEPTH],
  output logic                       valid_o   [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Next pointer/count state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; storage is left alone on reset since count defines validity.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Age-ordered view of the storage: index 0 is the head.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
      valid_o[k]   = (CNT_W'(k) < count_q);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Register write-back queue: merges load-path and ALU-path writes in program
// order, drains one per cycle into the register file, and forwards the
// youngest pending value to ID-stage operand lookups.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  reg_writeback_queue_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } lookup_t;

  logic [CNT_W-1:0]  count;
  logic              pop, space;
  logic              mem_take, alu_take, push;
  entry_t            push_entry, head;
  entry_t            entries [DEPTH];
  logic              valids  [DEPTH];
  logic              regwrite_q;
  logic [ADDR_W-1:0] rdaddr_q;
  logic [DATA_W-1:0] rddata_q;
  lookup_t           rs_look, rt_look;

  // Youngest matching pending entry wins, then older ones, then the output stage.
  function automatic lookup_t find_pending(input logic [ADDR_W-1:0] a,
                                           input entry_t ents [DEPTH],
                                           input logic vld [DEPTH],
                                           input logic ow,
                                           input logic [ADDR_W-1:0] oa,
                                           input logic [DATA_W-1:0] od);
    lookup_t r;
    r.hit  = 1'b0;
    r.data = '0;
    if (a != ADDR_W'(ZERO_REG)) begin
      if (ow && oa == a) begin
        r.hit  = 1'b1;
        r.data = od;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (vld[k] && ents[k].addr == a) begin
          r.hit  = 1'b1;
          r.data = ents[k].data;
        end
      end
    end
    return r;
  endfunction

  assign pop   = !bus.hold_i && (count != '0);
  assign space = (count < CNT_W'(DEPTH)) || pop;

  // Ready stays high in reset so producers are not stalled; the transfer is dropped.
  assign bus.mem_ready_o = rst_i || space;
  assign bus.alu_ready_o = rst_i || (space && !bus.mem_valid_i);

  assign mem_take = bus.mem_valid_i && bus.mem_ready_o;
  assign alu_take = bus.alu_valid_i && bus.alu_ready_o && !bus.mem_valid_i;

  // Arbitration and $0 filtering: the load path is the older instruction.
  always_comb begin
    push_entry.addr = bus.alu_addr_i;
    push_entry.data = bus.alu_data_i;
    push            = 1'b0;
    if (mem_take) begin
      push_entry.addr = bus.mem_addr_i;
      push_entry.data = bus.mem_data_i;
      push            = (bus.mem_addr_i != ADDR_W'(ZERO_REG));
    end else if (alu_take) begin
      push            = (bus.alu_addr_i != ADDR_W'(ZERO_REG));
    end
    if (rst_i) push = 1'b0;
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .entries_o    (entries),
    .valid_o      (valids)
  );

  // Register-file write port: one-cycle strobe per drained entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regwrite_q <= 1'b0;
      rdaddr_q   <= '0;
      rddata_q   <= '0;
    end else if (pop) begin
      regwrite_q <= 1'b1;
      rdaddr_q   <= head.addr;
      rddata_q   <= head.data;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  assign bus.RegWrite_o = regwrite_q;
  assign bus.RDaddr_o   = rdaddr_q;
  assign bus.RDdata_o   = rddata_q;

  // Operand forwarding lookups for the two read ports.
  always_comb begin
    rs_look = find_pending(bus.RSaddr_i, entries, valids, regwrite_q, rdaddr_q, rddata_q);
    rt_look = find_pending(bus.RTaddr_i, entries, valids, regwrite_q, rdaddr_q, rddata_q);
  end

  assign bus.RShit_o  = rs_look.hit;
  assign bus.RSdata_o = rs_look.data;
  assign bus.RThit_o  = rt_look.hit;
  assign bus.RTdata_o = rt_look.data;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus random traffic,
// all compared against a queue-level reference model.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_writeback_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            mo_v;
  logic [AW-1:0] mo_a;
  logic [DW-1:0] mo_d;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            precheck = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Youngest queued value for an address, else the value on the write port.
  function automatic logic [DW:0] ref_lookup(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return {1'b1, mq[i].d};
    if (mo_v && mo_a == a) return {1'b1, mo_d};
    return '0;
  endfunction

  task automatic idle();
    bus.mem_valid_i = 1'b0; bus.mem_addr_i = '0; bus.mem_data_i = '0;
    bus.alu_valid_i = 1'b0; bus.alu_addr_i = '0; bus.alu_data_i = '0;
  endtask

  task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mem_valid_i = 1'b1; bus.mem_addr_i = a; bus.mem_data_i = d;
  endtask

  task automatic set_alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = a; bus.alu_data_i = d;
  endtask

  // One clock: check combinational outputs, advance model on the edge, check state.
  task automatic cycle();
    logic [DW:0] rs, rt;
    bit popm, sp, am, aa;
    ent_t e;
    #1;
    popm = !bus.hold_i && mq.size() > 0;
    sp   = mq.size() < DEPTH || popm;
    if (precheck) begin
      chk("mem_ready", bus.mem_ready_o, rst ? 1'b1 : sp);
      chk("alu_ready", bus.alu_ready_o, rst ? 1'b1 : (sp && !bus.mem_valid_i));
      rs = ref_lookup(bus.RSaddr_i);
      rt = ref_lookup(bus.RTaddr_i);
      chk("rs_hit",  bus.RShit_o,  rs[DW]);
      chk("rs_data", bus.RSdata_o, rs[DW-1:0]);
      chk("rt_hit",  bus.RThit_o,  rt[DW]);
      chk("rt_data", bus.RTdata_o, rt[DW-1:0]);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mo_v = 0; mo_a = '0; mo_d = '0;
    end else begin
      am = bus.mem_valid_i && sp;
      aa = bus.alu_valid_i && sp && !bus.mem_valid_i;
      if (popm) begin
        e = mq.pop_front();
        mo_v = 1; mo_a = e.a; mo_d = e.d;
      end else begin
        mo_v = 0;
      end
      if (am && bus.mem_addr_i != 0) mq.push_back('{bus.mem_addr_i, bus.mem_data_i});
      else if (aa && bus.alu_addr_i != 0) mq.push_back('{bus.alu_addr_i, bus.alu_data_i});
    end
    #1;
    precheck = 1;
    chk("regwrite", bus.RegWrite_o, mo_v);
    chk("rdaddr",   bus.RDaddr_o,   mo_a);
    chk("rddata",   bus.RDdata_o,   mo_d);
    chk("count",    dut.u_fifo.count_o, mq.size());
  endtask

  initial begin
    logic [AW-1:0] exp_seq [5];
    exp_seq = '{5'd7, 5'd8, 5'd7, 5'd9, 5'd10};

    rst = 1'b1;
    idle();
    bus.hold_i = 1'b0; bus.RSaddr_i = 5'd3; bus.RTaddr_i = 5'd3;

    // Reset held two cycles with a load request pending
    set_mem(5'd3, 32'h33);
    cycle();
    cycle();
    chk("rst_we", bus.RegWrite_o, 1'b0);
    chk("rst_rshit", bus.RShit_o, 1'b0);
    rst = 1'b0;
    idle();
    cycle();
    cycle();
    chk("post_rst_we", bus.RegWrite_o, 1'b0);

    // Single ALU write
    set_alu(5'd5, 32'hDEADBEEF);
    cycle();
    idle();
    cycle();
    chk("single_we", bus.RegWrite_o, 1'b1);
    chk("single_addr", bus.RDaddr_o, 5'd5);
    chk("single_data", bus.RDdata_o, 32'hDEADBEEF);
    cycle();
    chk("single_end", bus.RegWrite_o, 1'b0);

    // Contention: load path first
    set_mem(5'd3, 32'h11);
    set_alu(5'd4, 32'h22);
    #1 chk("cont_alu_ready", bus.alu_ready_o, 1'b0);
    cycle();
    bus.mem_valid_i = 1'b0;
    cycle();
    chk("cont_first", bus.RDaddr_o, 5'd3);
    idle();
    cycle();
    chk("cont_second", bus.RDaddr_o, 5'd4);
    chk("cont_second_we", bus.RegWrite_o, 1'b1);
    cycle();

    // Fill under hold, look up, then drain with a waiting request
    bus.hold_i = 1'b1;
    set_alu(5'd7, 32'd1); cycle();
    set_alu(5'd8, 32'd5); cycle();
    set_alu(5'd7, 32'd2); cycle();
    set_alu(5'd9, 32'd3); cycle();
    idle();
    bus.RSaddr_i = 5'd7; bus.RTaddr_i = 5'd8;
    #1;
    chk("full_count", dut.u_fifo.count_o, 3'd4);
    chk("full_mem_ready", bus.mem_ready_o, 1'b0);
    chk("full_alu_ready", bus.alu_ready_o, 1'b0);
    chk("full_rs_hit", bus.RShit_o, 1'b1);
    chk("full_rs_data", bus.RSdata_o, 32'd2);
    chk("full_rt_data", bus.RTdata_o, 32'd5);
    cycle();
    bus.hold_i = 1'b0;
    set_alu(5'd10, 32'hA);
    #1 chk("drain_alu_ready", bus.alu_ready_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) idle();
      chk("drain_we", bus.RegWrite_o, 1'b1);
      chk("drain_addr", bus.RDaddr_o, exp_seq[i]);
    end
    cycle();

    // Register 0 is swallowed
    set_alu(5'd0, 32'hFFFF);
    bus.RSaddr_i = 5'd0;
    #1 chk("r0_ready", bus.alu_ready_o, 1'b1);
    cycle();
    idle();
    cycle();
    chk("r0_we", bus.RegWrite_o, 1'b0);
    chk("r0_hit", bus.RShit_o, 1'b0);
    cycle();

    // Reset with three pending entries
    bus.hold_i = 1'b1;
    set_mem(5'd1, 32'h101); cycle();
    set_mem(5'd2, 32'h102); cycle();
    set_mem(5'd3, 32'h103); cycle();
    idle();
    bus.hold_i = 1'b0;
    rst = 1'b1;
    cycle();
    chk("mid_rst_we", bus.RegWrite_o, 1'b0);
    chk("mid_rst_count", dut.u_fifo.count_o, 3'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mid_rst_nowrite", bus.RegWrite_o, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.mem_valid_i = ($urandom_range(0, 99) < 40);
      bus.mem_addr_i  = AW'($urandom_range(0, 15));
      bus.mem_data_i  = $urandom;
      bus.alu_valid_i = ($urandom_range(0, 99) < 50);
      bus.alu_addr_i  = AW'($urandom_range(0, 15));
      bus.alu_data_i  = $urandom;
      bus.hold_i      = ($urandom_range(0, 99) < 25);
      bus.RSaddr_i    = AW'($urandom_range(0, 15));
      bus.RTaddr_i    = AW'($urandom_range(0, 15));
      rst             = ($urandom_range(0, 99) < 2);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side companion to the pipeline register file. It collects register write requests from two producers, the ALU result path and the load/memory path. It queues them in program order and drives exactly one write per cycle into the register file write port (RegWrite/RDaddr/RDdata). While writes are pending, a combinational lookup port lets ID-stage operand reads obtain the youngest pending value before it lands in the register file.

## Interface
- DEPTH, 4: queue entries (power of two, ≥2)
- ADDR_W, 5: register address width
- DATA_W, 32: register data width

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- mem_valid_i / mem_ready_o  in/out  1  load-path request handshake
- mem_addr_i, mem_data_i  in  ADDR_W, DATA_W  load-path destination and value
- alu_valid_i / alu_ready_o  in/out  1  ALU-path request handshake
- alu_addr_i, alu_data_i  in  ADDR_W, DATA_W  ALU-path destination and value
- hold_i  in  1  suppress draining (register-file port busy / debug freeze)
- RegWrite_o  out  1  write strobe to register file (registered)
- RDaddr_o, RDdata_o  out  ADDR_W, DATA_W  write address/data (registered)
- RSaddr_i, RTaddr_i  in  ADDR_W  lookup addresses
- RShit_o, RThit_o  out  1  pending write exists for that address
- RSdata_o, RTdata_o  out  DATA_W  youngest pending value (0 when no hit)

## Operation
- Transfer occurs when valid && ready at a rising edge.
- Internal signals: pop = !hold_i && count>0; space = count<DEPTH || pop.
- One enqueue per cycle. Load path has priority (older instruction):
  - mem_ready_o = space
  - alu_ready_o = space && !mem_valid_i
- Address 0: the transfer completes (ready as normal), nothing is enqueued, count is unchanged. No write to $0 is ever emitted.
- Drain: on each edge with pop, the output registers load the head entry, RegWrite_o←1, and the head pointer advances. On an edge without pop, RegWrite_o←0; RDaddr_o/RDdata_o hold their values.
- Simultaneous push and pop when full is legal; count is unchanged.
- Lookup searches the queue entries and the output stage (when RegWrite_o=1).
  - Hit priority: youngest queue entry, then older entries, then the output stage.
  - Address 0 never hits.
  - Lookup is purely combinational from current state and ignores same-cycle incoming requests.
- No data transformation. Widths pass through unchanged. Pointers wrap modulo DEPTH. count is $clog2(DEPTH+1) bits wide.

## Timing
- Reset values: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, count=0, both pointers 0, RShit_o=RThit_o=0, RSdata_o=RTdata_o=0.
- Ready outputs during reset: high, but every transfer is discarded.
- Queue storage is not cleared on reset; validity comes from count.
- Reset mid-operation: all pending entries are dropped. RegWrite_o=0 from the first cycle after the reset edge. No stale write is emitted afterwards.
- Latency:
  - Request accepted at edge N into an empty queue, with hold_i low.
  - RegWrite_o=1 with that entry between edge N+1 and edge N+2.
  - The register file commits it at edge N+2.
- Throughput: one write per cycle sustained.
- Ready outputs are combinational from count, hold_i and mem_valid_i. Producers must not make valid depend on ready.
- RegWrite_o is a single-cycle pulse per entry. Back-to-back entries give consecutive high cycles.

## Structure
- Shared package wb_pkg holds:
  - ADDR_W and DATA_W defaults
  - typedef wb_entry_t {addr, data}
  - constant ZERO_REG = 0
- Sub-module wb_fifo: synchronous DEPTH-entry FIFO of wb_entry_t. It exposes count and all entries with per-entry valid, so the top level can run the lookup.
- Top level holds arbitration, address-0 filtering, the output registers and the lookup priority encoders.

## Test plan
- Reset: rst_i high for 2 cycles with mem_valid_i=1 (addr 3) → all outputs 0 throughout; no RegWrite_o after release.
- Single write: ALU (5, 0xDEADBEEF) accepted at edge N → RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF for exactly cycle N+1..N+2.
- Contention: mem (3, 0x11) and alu (4, 0x22) valid together → alu_ready_o=0, mem accepted first; alu accepted next edge; writes appear as 3 then 4 on consecutive cycles.
- Full plus lookup:
  - hold_i=1, push (7,1), (8,5), (7,2), (9,3) → count=4, both ready outputs 0.
  - RSaddr_i=7 → RShit_o=1, RSdata_o=2.
  - Release hold → drains 7, 8, 7, 9 one per cycle, and a waiting 5th request is accepted on the first drain edge.
- Register 0: ALU (0, 0xFFFF) → alu_ready_o=1, no RegWrite_o ever; RSaddr_i=0 → RShit_o=0.
- Reset mid-drain: 3 entries pending, assert rst_i for one edge → RegWrite_o=0 next cycle, no further writes, count=0.
